// File: rtl/frame_scheduler_pkg.sv
// Shared constants for the frame scheduler: state encoding, write-mux selects
// and frame buffer geometry.
package frame_scheduler_pkg;

  localparam int FB_ADDR_W = 19;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_CLR_START  = 4'd1;
  localparam logic [3:0] ST_CLR_GUARD  = 4'd2;
  localparam logic [3:0] ST_CLR_WAIT   = 4'd3;
  localparam logic [3:0] ST_PLOT_START = 4'd4;
  localparam logic [3:0] ST_PLOT_GUARD = 4'd5;
  localparam logic [3:0] ST_PLOT_WAIT  = 4'd6;
  localparam logic [3:0] ST_SWAP_WAIT  = 4'd7;
  localparam logic [3:0] ST_SWAP       = 4'd8;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_FILL = 2'b01;
  localparam logic [1:0] SEL_LINE = 2'b10;

  // The guard cycle already belongs to the drawer, so its writes pass through.
  function automatic logic [1:0] mux_sel(input logic [3:0] st);
    case (st)
      ST_CLR_GUARD, ST_CLR_WAIT:   return SEL_FILL;
      ST_PLOT_GUARD, ST_PLOT_WAIT: return SEL_LINE;
      default:                     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Drawer handshakes and frame buffer write bus between the scheduler (master)
// and the drawers / frame buffer (slave).
interface frame_scheduler_if;
  import frame_scheduler_pkg::*;

  logic                 fill_start;
  logic                 fill_ready;
  logic                 logic_start;
  logic                 logic_ready;
  logic                 fill_we;
  logic [FB_ADDR_W-1:0] fill_addr;
  logic                 fill_data;
  logic                 line_we;
  logic [FB_ADDR_W-1:0] line_addr;
  logic                 line_data;
  logic                 fb_we;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic                 fb_data;

  modport master (
    output fill_start, logic_start, fb_we, fb_addr, fb_data,
    input  fill_ready, logic_ready,
    input  fill_we, fill_addr, fill_data, line_we, line_addr, line_data
  );

  modport slave (
    input  fill_start, logic_start, fb_we, fb_addr, fb_data,
    output fill_ready, logic_ready,
    output fill_we, fill_addr, fill_data, line_we, line_addr, line_data
  );

endinterface

// File: rtl/frame_scheduler_fb_write_mux.sv
// Combinational frame buffer write mux: forwards the selected drawer's write
// request, all-zero when nothing is selected.
module fb_write_mux
  import frame_scheduler_pkg::*;
(
  input  logic [1:0]           sel,
  input  logic                 fill_we,
  input  logic [FB_ADDR_W-1:0] fill_addr,
  input  logic                 fill_data,
  input  logic                 line_we,
  input  logic [FB_ADDR_W-1:0] line_addr,
  input  logic                 line_data,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_data
);

  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = 1'b0;
    case (sel)
      SEL_FILL: begin
        fb_we   = fill_we;
        fb_addr = fill_addr;
        fb_data = fill_data;
      end
      SEL_LINE: begin
        fb_we   = line_we;
        fb_addr = line_addr;
        fb_data = line_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: clear -> plot -> wait for vsync -> swap, back-to-back while
// enabled. Define FRAME_SCHEDULER_DROP_CNT_EN to count missed vsync pulses.
module frame_scheduler
  import frame_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      vsync,
  frame_scheduler_if.master         bus,
  output logic                      swap,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               dropped_frames
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [1:0] sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Guard states exist because ready may still be high from before the start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (enable) state_nxt = ST_CLR_START;
      ST_CLR_START:  state_nxt = ST_CLR_GUARD;
      ST_CLR_GUARD:  state_nxt = ST_CLR_WAIT;
      ST_CLR_WAIT:   if (bus.fill_ready) state_nxt = ST_PLOT_START;
      ST_PLOT_START: state_nxt = ST_PLOT_GUARD;
      ST_PLOT_GUARD: state_nxt = ST_PLOT_WAIT;
      ST_PLOT_WAIT:  if (bus.logic_ready) state_nxt = ST_SWAP_WAIT;
      ST_SWAP_WAIT:  if (vsync) state_nxt = ST_SWAP;
      ST_SWAP:       state_nxt = enable ? ST_CLR_START : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  assign bus.fill_start  = (state == ST_CLR_START);
  assign bus.logic_start = (state == ST_PLOT_START);
  assign swap            = (state == ST_SWAP);
  assign frame_done      = (state == ST_SWAP);
  assign busy            = (state != ST_IDLE);
  assign sel             = mux_sel(state);

  fb_write_mux u_fb_write_mux (
    .sel       (sel),
    .fill_we   (bus.fill_we),
    .fill_addr (bus.fill_addr),
    .fill_data (bus.fill_data),
    .line_we   (bus.line_we),
    .line_addr (bus.line_addr),
    .line_data (bus.line_data),
    .fb_we     (bus.fb_we),
    .fb_addr   (bus.fb_addr),
    .fb_data   (bus.fb_data)
  );

`ifdef FRAME_SCHEDULER_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic        drop_evt;

  assign drop_evt = vsync && (state != ST_IDLE) && (state != ST_SWAP_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_cnt <= '0;
    else if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
  end

  assign dropped_frames = drop_cnt;
`else
  assign dropped_frames = '0;
`endif

endmodule
